rattlesnake_irq_arbiter: RTL

//  Consumes timer_triggered from the machine timer, a software-interrupt bit and NUM_EXT_IRQ async external lines.

---
 rtl/rattlesnake_irq_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rattlesnake_irq_arbiter.sv
// Machine-level interrupt arbiter: forms MIP, masks and prioritises MEI/MSI/MTI, one request to the core at a time.
// Build option IRQ_EXT_EDGE_EN: external lines are edge-latched (cleared by ext_clr) instead of level.
`ifndef XLEN
`define XLEN 32
`endif

module rattlesnake_irq_arbiter #(
  parameter int unsigned NUM_EXT_IRQ = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ID_W        = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   timer_triggered,
  input  logic                   msip_set,
  input  logic                   msip_clr,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq,
  input  logic [NUM_EXT_IRQ-1:0] ext_mask,
  input  logic [NUM_EXT_IRQ-1:0] ext_clr,
  input  logic                   mie_meie,
  input  logic                   mie_mtie,
  input  logic                   mie_msie,
  input  logic                   mstatus_mie,
  input  logic                   irq_ack,
  input  logic                   mret_done,
  output logic                   irq_req,
  output logic [`XLEN-1:0]       irq_cause,
  output logic [ID_W-1:0]        irq_ext_id,
  output logic [2:0]             mip_out,
  output logic [NUM_EXT_IRQ-1:0] ext_pending
);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t                 state;
  logic [NUM_EXT_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_EXT_IRQ-1:0] synced;
  logic [NUM_EXT_IRQ-1:0] ext_hit;
  logic                   msip;
  logic                   meip;
  logic                   eligible;
  logic [3:0]             code;
  logic [ID_W-1:0]        ext_win;
  logic                   elig_q;
  logic [3:0]             code_q;
  logic [ID_W-1:0]        id_q;
  logic [`XLEN-1:0]       cause_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else if (sync_reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_irq;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef IRQ_EXT_EDGE_EN
  logic [NUM_EXT_IRQ-1:0] synced_prev;

  // A fresh rising edge outranks a clear strobe arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      synced_prev <= '0;
      ext_pending <= '0;
    end else if (sync_reset) begin
      synced_prev <= '0;
      ext_pending <= '0;
    end else begin
      synced_prev <= synced;
      ext_pending <= (ext_pending & ~ext_clr) | (synced & ~synced_prev);
    end
  end
`else
  logic unused_ext_clr;
  assign unused_ext_clr = ^ext_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        ext_pending <= '0;
    else if (sync_reset) ext_pending <= '0;
    else                 ext_pending <= synced;
  end
`endif

  assign ext_hit = ext_pending & ext_mask;
  assign meip    = |ext_hit;

  always_comb begin
    ext_win = '0;
    for (int unsigned i = NUM_EXT_IRQ; i > 0; i--) begin
      if (ext_hit[i-1]) ext_win = ID_W'(i - 1);
    end
  end

  always_comb begin
    eligible = mstatus_mie & ((meip & mie_meie) | (msip & mie_msie) | (timer_triggered & mie_mtie));
    code     = 4'd7;
    if (meip & mie_meie)      code = 4'd11;
    else if (msip & mie_msie) code = 4'd3;
  end

  always_comb begin
    cause_next              = '0;
    cause_next[`XLEN-1]     = 1'b1;
    cause_next[3:0]         = code_q;
  end

  // Arbitration result is registered so the FSM latches a stable, self-consistent cause/id pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msip    <= 1'b0;
      mip_out <= '0;
      elig_q  <= 1'b0;
      code_q  <= '0;
      id_q    <= '0;
    end else if (sync_reset) begin
      msip    <= 1'b0;
      mip_out <= '0;
      elig_q  <= 1'b0;
      code_q  <= '0;
      id_q    <= '0;
    end else begin
      if (msip_clr)      msip <= 1'b0;
      else if (msip_set) msip <= 1'b1;
      mip_out <= {meip, timer_triggered, msip};
      elig_q  <= eligible;
      code_q  <= code;
      id_q    <= ext_win;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      irq_cause  <= '0;
      irq_ext_id <= '0;
    end else if (sync_reset) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      irq_cause  <= '0;
      irq_ext_id <= '0;
    end else begin
      case (state)
        IDLE: if (elig_q) begin
          state      <= REQ;
          irq_req    <= 1'b1;
          irq_cause  <= cause_next;
          irq_ext_id <= id_q;
        end
        REQ: if (irq_ack) begin
          state   <= BUSY;
          irq_req <= 1'b0;
        end else if (!mstatus_mie) begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
        BUSY: if (mret_done) state <= IDLE;
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
